// File: rtl/t08_mem_arbiter_pkg.sv
// Shared types and bus widths for the IF/DS memory-port arbiter.
package t08_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DS
  } arb_owner_t;

endpackage

// File: rtl/t08_mem_arbiter.sv
// Arbitrates the single memory/bus port between instruction fetch (IF) and load/store (DS),
// issuing one bus command per grant and returning data with a one-cycle ack.
module t08_mem_arbiter
  import t08_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ds_req,
  input  logic              ds_we,
  input  logic [ADDR_W-1:0] ds_addr,
  input  logic [DATA_W-1:0] ds_wdata,
  output logic              ds_ack,
  output logic [DATA_W-1:0] ds_rdata,
  output logic              ds_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  input  logic              mem_done,
  output logic              freeze
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned STK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DATA_STREAK);

  arb_state_t        state_q;
  arb_owner_t        owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [STK_W-1:0]  streak_q;
  logic [STK_W-1:0]  streak_d;
  logic              if_ack_q;
  logic              ds_ack_q;
  logic              err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ds_rdata_q;

  logic grant_ds;
  logic grant_if;

  // DS wins unless it has used up its streak while IF is waiting.
  always_comb begin
    grant_ds = ds_req && ((streak_q < STK_MAX) || !if_req);
    grant_if = !grant_ds && if_req;
    streak_d = streak_q;
    if (grant_ds) begin
      if (!if_req) begin
        streak_d = '0;
      end else if (streak_q < STK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
    end else if (grant_if) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      tmo_q      <= '0;
      streak_q   <= '0;
      if_ack_q   <= 1'b0;
      ds_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      ds_rdata_q <= '0;
    end else begin
      if_ack_q <= 1'b0;
      ds_ack_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_ds || grant_if) begin
            owner_q  <= grant_ds ? OWN_DS : OWN_IF;
            addr_q   <= grant_ds ? ds_addr : if_addr;
            wdata_q  <= grant_ds ? ds_wdata : '0;
            rd_q     <= !(grant_ds && ds_we);
            wr_q     <= grant_ds && ds_we;
            streak_q <= streak_d;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_busy) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            tmo_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // A done arriving on the last allowed cycle still counts as a normal completion.
          if (mem_done || (tmo_q == TMO_LAST)) begin
            err_q   <= !mem_done;
            state_q <= RESP;
            if (owner_q == OWN_DS) begin
              ds_ack_q   <= 1'b1;
              ds_rdata_q <= mem_done ? mem_rdata : '0;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_done ? mem_rdata : '0;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ds_ack    = ds_ack_q;
  assign ds_rdata  = ds_rdata_q;
  assign ds_err    = err_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign freeze    = (state_q != IDLE) | if_req | ds_req;

endmodule

// File: tb/tb_t08_mem_arbiter.sv
// Directed and randomized checks of t08_mem_arbiter against a transaction-level model.
module tb_t08_mem_arbiter;

  localparam int unsigned TB_TMO    = 8;
  localparam int unsigned TB_STREAK = 4;

  logic        clk, nrst;
  logic        if_req, ds_req, ds_we;
  logic [31:0] if_addr, ds_addr, ds_wdata;
  logic        if_ack, ds_ack, ds_err;
  logic [31:0] if_rdata, ds_rdata;
  logic        mem_read, mem_write, mem_busy, mem_done, freeze;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned total, bad;

  bit          active, own_ds, lat_we, exp_err, ds_hold, auto_mode, force_en, last_err_obs;
  int          phase, ncyc, exp_ack_n, done_at, acc_n, last_acc_n;
  int unsigned streak, busy_left, delay, busy_cfg, delay_cfg, cmd_cycles, last_cmd_cycles;
  logic [31:0] lat_addr, lat_wdata, done_data, exp_data, force_data;
  logic [31:0] done_addr_obs, done_wdata_obs;
  bit          grant_log[$];
  bit          ack_log[$];
  int          cmd_n_log[$];
  int          ack_n_log[$];

  t08_mem_arbiter #(
    .TIMEOUT_CYCLES (TB_TMO),
    .MAX_DATA_STREAK(TB_STREAK)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .ds_req   (ds_req),
    .ds_we    (ds_we),
    .ds_addr  (ds_addr),
    .ds_wdata (ds_wdata),
    .ds_ack   (ds_ack),
    .ds_rdata (ds_rdata),
    .ds_err   (ds_err),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_busy (mem_busy),
    .mem_done (mem_done),
    .freeze   (freeze)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, compare with the model, then drive the bus reply.
  task automatic step();
    logic        cmd_now, exp_ifa, exp_dsa;
    int unsigned eff;
    @(negedge clk);
    ncyc++;
    cmd_now = mem_read | mem_write;
    if (!active && cmd_now) begin
      chk1("grant_has_req", if_req | ds_req, 1'b1);
      own_ds = ds_req && ((streak < TB_STREAK) || !if_req);
      if (own_ds) streak = if_req ? ((streak < TB_STREAK) ? streak + 1 : streak) : 0;
      else streak = 0;
      lat_we    = own_ds && ds_we;
      lat_addr  = own_ds ? ds_addr : if_addr;
      lat_wdata = ds_wdata;
      active    = 1'b1;
      phase     = 1;
      cmd_cycles = 0;
      exp_ack_n = -1;
      grant_log.push_back(own_ds);
      cmd_n_log.push_back(ncyc);
      if (auto_mode) begin
        busy_left = $urandom_range(0, 3);
        delay     = $urandom_range(0, 10);
      end else begin
        busy_left = busy_cfg;
        delay     = delay_cfg;
      end
    end
    if (ncyc == done_at) begin
      done_addr_obs  = mem_addr;
      done_wdata_obs = mem_wdata;
    end
    mem_busy = 1'b0;
    if (active) begin
      chk1("cmd_rd", mem_read, (phase == 1) && !lat_we);
      chk1("cmd_wr", mem_write, (phase == 1) && lat_we);
      chk32("cmd_addr", mem_addr, lat_addr);
      if (lat_we) chk32("cmd_wdata", mem_wdata, lat_wdata);
    end
    if (active && phase == 1) begin
      cmd_cycles++;
      if (busy_left > 0) begin
        mem_busy = 1'b1;
        busy_left--;
      end else begin
        phase     = 2;
        acc_n     = ncyc;
        eff       = (delay == 0 || delay > TB_TMO) ? TB_TMO : delay;
        exp_ack_n = ncyc + int'(eff) + 1;
        exp_err   = (delay == 0 || delay > TB_TMO);
        done_data = force_en ? force_data : $urandom();
        exp_data  = exp_err ? 32'h0 : done_data;
        done_at   = (delay != 0) ? ncyc + int'(delay) : -1;
        last_cmd_cycles = cmd_cycles;
      end
    end
    exp_ifa = active && (phase == 2) && (ncyc == exp_ack_n) && !own_ds;
    exp_dsa = active && (phase == 2) && (ncyc == exp_ack_n) && own_ds;
    chk1("if_ack", if_ack, exp_ifa);
    chk1("ds_ack", ds_ack, exp_dsa);
    chk1("ds_err", ds_err, (exp_ifa | exp_dsa) & exp_err);
    if (exp_ifa) chk32("if_rdata", if_rdata, exp_data);
    if (exp_dsa) chk32("ds_rdata", ds_rdata, exp_data);
    chk1("freeze", freeze, active | if_req | ds_req);
    if (exp_ifa || exp_dsa) begin
      active = 1'b0;
      phase  = 0;
      last_err_obs = ds_err;
      last_acc_n   = acc_n;
      ack_log.push_back(own_ds);
      ack_n_log.push_back(ncyc);
      if (exp_ifa) if_req = 1'b0;
      else if (ds_hold) ds_addr = ds_addr + 32'd4;
      else ds_req = 1'b0;
    end
    mem_done  = (ncyc == done_at);
    mem_rdata = mem_done ? done_data : $urandom();
    if (auto_mode) begin
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!ds_req && $urandom_range(0, 3) == 0) begin
        ds_req   = 1'b1;
        ds_we    = 1'($urandom_range(0, 1));
        ds_addr  = $urandom();
        ds_wdata = $urandom();
      end
    end
  endtask

  task automatic wait_idle(input int unsigned maxc);
    int unsigned k;
    k = 0;
    while ((active || if_req || ds_req) && k < maxc) begin
      step();
      k++;
    end
    total++;
    assert (k < maxc) else begin
      bad++;
      $error("FAIL wait_bound observed=%0d expected_below=%0d", k, maxc);
    end
    step();
  endtask

  initial begin
    int gl, al;
    total = 0; bad = 0;
    active = 0; phase = 0; ncyc = 0; exp_ack_n = -1; done_at = -1; acc_n = 0; last_acc_n = 0;
    streak = 0; busy_left = 0; delay = 0; busy_cfg = 0; delay_cfg = 1; cmd_cycles = 0;
    last_cmd_cycles = 0; ds_hold = 0; auto_mode = 0; force_en = 0; force_data = '0;
    own_ds = 0; lat_we = 0; exp_err = 0; last_err_obs = 0;
    lat_addr = '0; lat_wdata = '0; done_data = '0; exp_data = '0;
    done_addr_obs = '0; done_wdata_obs = '0;
    nrst = 1'b0; if_req = 0; ds_req = 0; ds_we = 0;
    if_addr = '0; ds_addr = '0; ds_wdata = '0;
    mem_rdata = '0; mem_busy = 0; mem_done = 0;

    #1;
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_ds_ack", ds_ack, 1'b0);
    chk1("rst_ds_err", ds_err, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_ds_rdata", ds_rdata, 32'h0);
    chk1("rst_freeze", freeze, 1'b0);
    #11 nrst = 1'b1;
    step();

    // Single load, done two cycles after accept.
    al = ack_log.size();
    ds_req = 1; ds_we = 0; ds_addr = 32'h100;
    busy_cfg = 0; delay_cfg = 2; force_en = 1; force_data = 32'hDEAD_BEEF;
    wait_idle(50);
    force_en = 0;
    chk32("t1_ack_count", ack_log.size() - al, 32'd1);
    chk1("t1_owner_ds", ack_log[al], 1'b1);
    chk32("t1_ds_rdata", ds_rdata, 32'hDEAD_BEEF);
    chk32("t1_latency", 32'(ack_n_log[al] - cmd_n_log[cmd_n_log.size()-1]), 32'd3);

    // Simultaneous requests: DS first, IF after one idle bubble.
    gl = grant_log.size(); al = ack_log.size();
    if_req = 1; if_addr = 32'h80;
    ds_req = 1; ds_we = 0; ds_addr = 32'h104;
    delay_cfg = 1;
    wait_idle(50);
    chk1("t2_first_ds", grant_log[gl], 1'b1);
    chk1("t2_second_if", grant_log[gl+1], 1'b0);
    chk1("t2_ack_if", ack_log[al+1], 1'b0);
    chk32("t2_bubble", 32'(cmd_n_log[gl+1] - ack_n_log[al]), 32'd2);

    // DS held continuously with IF pending: DS x4 then IF.
    gl = grant_log.size();
    ds_hold = 1; ds_req = 1; ds_we = 0; ds_addr = 32'h400;
    if_req = 1; if_addr = 32'h500;
    for (int k = 0; k < 300 && grant_log.size() < gl + 5; k++) step();
    ds_hold = 0;
    wait_idle(100);
    for (int i = 0; i < 5; i++) chk1($sformatf("t3_grant%0d", i), grant_log[gl+i], (i < 4));

    // Store with three busy cycles.
    ds_req = 1; ds_we = 1; ds_addr = 32'h40; ds_wdata = 32'h0000_00AB;
    busy_cfg = 3; delay_cfg = 2;
    wait_idle(50);
    busy_cfg = 0;
    chk32("t4_write_cycles", last_cmd_cycles, 32'd4);
    chk32("t4_addr_at_done", done_addr_obs, 32'h40);
    chk32("t4_wdata_at_done", done_wdata_obs, 32'hAB);

    // No completion: timeout with error.
    ds_req = 1; ds_we = 0; ds_addr = 32'h44;
    delay_cfg = 0;
    wait_idle(50);
    chk1("t5_err", last_err_obs, 1'b1);
    chk32("t5_rdata", ds_rdata, 32'h0);
    chk32("t5_ack_delay", 32'(ack_n_log[ack_n_log.size()-1] - last_acc_n), 32'(TB_TMO + 1));

    // Asynchronous reset during WAIT.
    if_req = 1; if_addr = 32'h200; delay_cfg = 0;
    for (int k = 0; k < 50 && phase != 2; k++) step();
    chk32("t6_reach_wait", 32'(phase), 32'd2);
    step();
    #2 nrst = 1'b0;
    #1;
    chk1("t6_mem_read", mem_read, 1'b0);
    chk1("t6_mem_write", mem_write, 1'b0);
    chk32("t6_mem_addr", mem_addr, 32'h0);
    chk1("t6_if_ack", if_ack, 1'b0);
    chk32("t6_if_rdata", if_rdata, 32'h0);
    chk32("t6_ds_rdata", ds_rdata, 32'h0);
    active = 0; phase = 0; done_at = -1; streak = 0; if_req = 0;
    #1 chk1("t6_freeze", freeze, 1'b0);
    repeat (2) step();
    #2 nrst = 1'b1;
    al = ack_log.size();
    if_req = 1; if_addr = 32'h300; delay_cfg = 1;
    wait_idle(50);
    chk32("t6_post_acks", ack_log.size() - al, 32'd1);
    chk1("t6_post_owner_if", ack_log[al], 1'b0);

    // Randomized traffic against the model.
    auto_mode = 1;
    repeat (1500) step();
    auto_mode = 0;
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
